// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter family.
package fifo_arb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational circular priority picker: the first requester with req high,
// searching from rr_ptr+1 upwards and wrapping at NUM_REQ-1.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi sits gi+1 positions after rr_ptr; the sum never reaches
    // 2*NUM_REQ, so a single conditional subtract performs the wrap.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum_w;
            logic [IDX_W:0] wrap_w;
            assign sum_w         = {1'b0, rr_ptr} + (IDX_W+1)'(gi + 1);
            assign wrap_w        = (sum_w >= (IDX_W+1)'(NUM_REQ)) ?
                                   (sum_w - (IDX_W+1)'(NUM_REQ)) : sum_w;
            assign cand_idx[gi]  = wrap_w[IDX_W-1:0];
            assign cand_hit[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                found = 1'b1;
                idx   = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of the UART byte FIFO write port. One requester holds the
// grant for a packet or BURST_MAX bytes; writes are gated on fifo_full.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_write_enable,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(BURST_MAX + 1);

    arb_state_t         state_reg, state_next;
    logic [ID_W-1:0]    grant_id_reg, grant_id_next;
    logic               grant_valid_reg, grant_valid_next;
    logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [BURST_W-1:0] burst_cnt_reg, burst_cnt_next;

    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic               cur_req;
    logic               cur_last;
    logic               write_en;
    logic [BURST_W-1:0] burst_inc;
    logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // Per-requester data slices and one-hot ack decode against the grant.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign data_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign ack[gi]        = write_en && (grant_id_reg == ID_W'(gi));
        end
    endgenerate

    assign cur_req           = req[grant_id_reg];
    assign cur_last          = req_last[grant_id_reg];
    assign write_en          = (state_reg == XFER) && cur_req && !fifo_full;
    assign burst_inc         = burst_cnt_reg + BURST_W'(1);
    assign fifo_write_enable = write_en;
    assign fifo_data_in      = data_slice[grant_id_reg];
    assign grant_valid       = grant_valid_reg;
    assign grant_id          = grant_id_reg;

    // Next-state logic: arbitrate in IDLE, count bytes and release in XFER.
    always_comb begin
        state_next       = state_reg;
        grant_id_next    = grant_id_reg;
        grant_valid_next = grant_valid_reg;
        rr_ptr_next      = rr_ptr_reg;
        burst_cnt_next   = burst_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next       = XFER;
                    grant_id_next    = pick_idx;
                    grant_valid_next = 1'b1;
                    burst_cnt_next   = '0;
                end
            end
            XFER: begin
                if (write_en) begin
                    burst_cnt_next = burst_inc;
                    if (cur_last || (burst_inc == BURST_W'(BURST_MAX))) begin
                        state_next       = IDLE;
                        grant_valid_next = 1'b0;
                        rr_ptr_next      = grant_id_reg;
                    end
                end else if (!cur_req) begin
                    // Requester walked away mid-packet; release the port.
                    state_next       = IDLE;
                    grant_valid_next = 1'b0;
                    rr_ptr_next      = grant_id_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and grant registers; rr_ptr starts at the top so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            grant_id_reg    <= '0;
            grant_valid_reg <= 1'b0;
            rr_ptr_reg      <= ID_W'(NUM_REQ - 1);
            burst_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            grant_id_reg    <= grant_id_next;
            grant_valid_reg <= grant_valid_next;
            rr_ptr_reg      <= rr_ptr_next;
            burst_cnt_reg   <= burst_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: a cycle table for the single-requester and
// full-stall sequences, a requester model with a write scoreboard for
// round-robin, burst-cap and abandon, and a hand-written async-reset sequence.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_write_enable;
    logic [7:0]  fifo_data_in;
    logic        grant_valid;
    logic [1:0]  grant_id;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_write_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .BURST_MAX  (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .req_data          (req_data),
        .req_last          (req_last),
        .ack               (ack),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_data_in      (fifo_data_in),
        .grant_valid       (grant_valid),
        .grant_id          (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic        e_gv;
        logic [1:0]  e_gid;
        logic        e_we;
        logic [3:0]  e_ack;
        logic        e_dchk;
        logic [7:0]  e_dout;
    } vec_t;

    vec_t vt [13];

    // ---------------- requester model + scoreboard ----------------
    typedef struct {
        logic [7:0] d;
        logic       last;
    } byte_rec_t;

    typedef struct {
        int         id;
        logic [7:0] d;
        int         gap;
    } exp_t;

    byte_rec_t mem [4][8];
    int        head [4];
    int        tail [4];
    int        lim  [4];
    exp_t      exp_q [$];

    task automatic clr_model();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
            lim[i]  = 0;
        end
        exp_q.delete();
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic last);
        mem[r][tail[r]].d    = d;
        mem[r][tail[r]].last = last;
        tail[r]++;
        lim[r] = tail[r];
    endtask

    task automatic expect_wr(input int id, input logic [7:0] d, input int gap);
        exp_t e;
        e.id  = id;
        e.d   = d;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        req       = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_sb(input string name, input int max_cyc);
        int   n;
        int   last_wr;
        int   wid;
        exp_t e;
        n       = 0;
        last_wr = -1;
        while (exp_q.size() > 0 && n < max_cyc) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                req[i] = (head[i] < lim[i]);
                if (head[i] < 8) begin
                    req_data[i*8 +: 8] = mem[i][head[i]].d;
                    req_last[i]        = mem[i][head[i]].last;
                end else begin
                    req_data[i*8 +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
            fifo_full = 1'b0;
            #1;
            if (fifo_write_enable) begin
                wid = int'(grant_id);
                for (int i = 0; i < 4; i++) if (ack[i]) wid = i;
                check({name, "_ack_onehot"}, $countones(ack), 1);
                e = exp_q.pop_front();
                $display("%s: wr id=%0d data=%02h cyc=%0d", name, wid, fifo_data_in, n);
                check({name, "_id"}, wid, e.id);
                check({name, "_gid"}, grant_id, e.id);
                check({name, "_data"}, fifo_data_in, e.d);
                if (e.gap != 0) check({name, "_gap"}, n - last_wr, e.gap);
                last_wr = n;
                if (wid >= 0 && wid < 4) head[wid]++;
            end else begin
                check({name, "_noack"}, ack, 4'b0000);
            end
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        @(negedge clk);
        req = '0;
        #1;
        check({name, "_quiet"}, fifo_write_enable, 1'b0);
    endtask

    initial begin
        //              req     data          last   full gv gid we ack     dchk dout
        vt[0]  = '{4'b0100, 32'h0041_0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 8'h00};
        vt[1]  = '{4'b0100, 32'h0041_0000, 4'b0000, 0, 1, 2, 1, 4'b0100, 1, 8'h41};
        vt[2]  = '{4'b0100, 32'h0042_0000, 4'b0000, 0, 1, 2, 1, 4'b0100, 1, 8'h42};
        vt[3]  = '{4'b0100, 32'h0043_0000, 4'b0100, 0, 1, 2, 1, 4'b0100, 1, 8'h43};
        vt[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 2, 0, 4'b0000, 0, 8'h00};
        vt[5]  = '{4'b0001, 32'h0000_0010, 4'b0000, 0, 0, 2, 0, 4'b0000, 0, 8'h00};
        vt[6]  = '{4'b0001, 32'h0000_0010, 4'b0000, 0, 1, 0, 1, 4'b0001, 1, 8'h10};
        vt[7]  = '{4'b0001, 32'h0000_0011, 4'b0000, 1, 1, 0, 0, 4'b0000, 1, 8'h11};
        vt[8]  = '{4'b0001, 32'h0000_0011, 4'b0000, 1, 1, 0, 0, 4'b0000, 1, 8'h11};
        vt[9]  = '{4'b0001, 32'h0000_0011, 4'b0000, 1, 1, 0, 0, 4'b0000, 1, 8'h11};
        vt[10] = '{4'b0001, 32'h0000_0011, 4'b0000, 0, 1, 0, 1, 4'b0001, 1, 8'h11};
        vt[11] = '{4'b0001, 32'h0000_0012, 4'b0001, 0, 1, 0, 1, 4'b0001, 1, 8'h12};
        vt[12] = '{4'b0000, 32'h0000_0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 8'h00};

        reset     = 1'b1;
        req       = 4'b1111;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        clr_model();

        // Reset state, with every requester asserting during reset.
        repeat (2) @(negedge clk);
        #1;
        check("rst_gv", grant_valid, 1'b0);
        check("rst_gid", grant_id, 2'd0);
        check("rst_we", fifo_write_enable, 1'b0);
        check("rst_ack", ack, 4'b0000);
        req   = '0;
        reset = 1'b0;

        // Single requester then full stall, cycle by cycle.
        for (int r = 0; r < 13; r++) begin
            @(negedge clk);
            req       = vt[r].req;
            req_data  = vt[r].data;
            req_last  = vt[r].last;
            fifo_full = vt[r].full;
            #1;
            $display("row %0d: gv=%0d gid=%0d we=%0d ack=%b dout=%02h",
                     r, grant_valid, grant_id, fifo_write_enable, ack, fifo_data_in);
            check($sformatf("row%0d_gv", r), grant_valid, vt[r].e_gv);
            check($sformatf("row%0d_gid", r), grant_id, vt[r].e_gid);
            check($sformatf("row%0d_we", r), fifo_write_enable, vt[r].e_we);
            check($sformatf("row%0d_ack", r), ack, vt[r].e_ack);
            if (vt[r].e_dchk) check($sformatf("row%0d_dout", r), fifo_data_in, vt[r].e_dout);
        end

        // Round-robin: all four request continuously, every byte ends a packet.
        do_reset();
        clr_model();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 4; r++) begin
                push_byte(r, 8'((r << 4) | k), 1'b1);
                expect_wr(r, 8'((r << 4) | k), (k == 0 && r == 0) ? 0 : 2);
            end
        end
        run_sb("rr", 60);

        // Burst cap: 6-byte packet from 1 is split around requester 3.
        do_reset();
        clr_model();
        for (int k = 0; k < 6; k++) push_byte(1, 8'(8'h10 + k), k == 5);
        push_byte(3, 8'h30, 1'b1);
        expect_wr(1, 8'h10, 0);
        expect_wr(1, 8'h11, 1);
        expect_wr(1, 8'h12, 1);
        expect_wr(1, 8'h13, 1);
        expect_wr(3, 8'h30, 2);
        expect_wr(1, 8'h14, 2);
        expect_wr(1, 8'h15, 1);
        run_sb("burst", 60);

        // Abandon: requester 0 stops after 1 of 3 bytes, 1 takes over.
        do_reset();
        clr_model();
        push_byte(0, 8'h00, 1'b0);
        push_byte(0, 8'h01, 1'b0);
        push_byte(0, 8'h02, 1'b1);
        lim[0] = 1;
        push_byte(1, 8'h10, 1'b0);
        push_byte(1, 8'h11, 1'b1);
        expect_wr(0, 8'h00, 0);
        expect_wr(1, 8'h10, 3);
        expect_wr(1, 8'h11, 1);
        run_sb("abandon", 60);

        // Async reset in the middle of a transfer.
        do_reset();
        @(negedge clk);
        req      = 4'b0100;
        req_data = 32'h0055_0000;
        req_last = 4'b0000;
        @(negedge clk);
        #1;
        check("arst_pre_we", fifo_write_enable, 1'b1);
        check("arst_pre_gid", grant_id, 2'd2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_we", fifo_write_enable, 1'b0);
        check("arst_ack", ack, 4'b0000);
        check("arst_gv", grant_valid, 1'b0);
        req      = 4'b0101;
        req_data = 32'h0055_0066;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        $display("post-reset: gv=%0d gid=%0d we=%0d dout=%02h",
                 grant_valid, grant_id, fifo_write_enable, fifo_data_in);
        check("arst_post_gv", grant_valid, 1'b1);
        check("arst_post_gid", grant_id, 2'd0);
        check("arst_post_we", fifo_write_enable, 1'b1);
        check("arst_post_dout", fifo_data_in, 8'h66);
        req = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
